// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 byte-stream adapter:
//   - aes_state_e     : adapter control states
//   - AES_* sizes     : block/frame byte counts and byte width
//   - FIPS_* vectors  : FIPS-197 known-answer vectors (key, plaintext,
//                       ciphertext), reused by the testbench core model
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    CLEAR   = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    DRAIN   = 3'd4
  } aes_state_e;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_FRAME_BYTES = 32;
  localparam int AES_BYTE_W      = 8;
  localparam int AES_BLOCK_W     = AES_BLOCK_BYTES * AES_BYTE_W;

  // FIPS-197 Appendix C.1 vector
  localparam logic [127:0] FIPS_KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // FIPS-197 Appendix B vector
  localparam logic [127:0] FIPS_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

endpackage

// File: rtl/aes_out_serializer.sv
// ---------------------------------------------------------------------------
// aes_out_serializer
// Holds a captured 128-bit ciphertext and returns it MSB byte first over a
// valid/ready byte stream.
//   clk, rst       : clock, asynchronous active-high reset
//   load_i         : capture data_i and restart the byte count
//   data_i         : 128-bit block to serialize
//   valid_i        : stream valid (owned by the parent FSM)
//   m_ready_i      : downstream ready
//   m_data_o       : current byte, always the top byte of the shift register
//   m_last_o       : high while the 16th byte is presented
//   last_beat_o    : handshake of the 16th byte this cycle
// ---------------------------------------------------------------------------
module aes_out_serializer
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [AES_BLOCK_W-1:0] data_i,
  input  logic                   valid_i,
  input  logic                   m_ready_i,
  output logic [AES_BYTE_W-1:0]  m_data_o,
  output logic                   m_last_o,
  output logic                   last_beat_o
);

  logic [AES_BLOCK_W-1:0] sr_q, sr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic                   beat;

  assign beat        = valid_i & m_ready_i;
  assign last_beat_o = beat & (cnt_q == 4'd15);
  assign m_data_o    = sr_q[AES_BLOCK_W-1 -: AES_BYTE_W];
  assign m_last_o    = last_q;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (load_i) begin
      sr_d   = data_i;
      cnt_d  = 4'd0;
      last_d = 1'b0;
    end else if (beat) begin
      sr_d   = sr_q << AES_BYTE_W;
      cnt_d  = cnt_q + 4'd1;
      // m_last is registered, so it is raised on the beat that moves to byte 15
      last_d = (cnt_q == 4'd14);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= 4'd0;
      last_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/aes_stream_adapter.sv
// ---------------------------------------------------------------------------
// aes_stream_adapter
// Byte-stream front-end for an iterative AES-128 core. Collects 16 key bytes
// then 16 plaintext bytes, pulses core_clr then core_start, waits for
// core_done under a watchdog and streams the 16 ciphertext bytes back.
//   clk, rst              : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data: input byte stream (ready only while collecting)
//   m_valid/m_ready/m_data/m_last : ciphertext byte stream
//   core_clr, core_start  : one-cycle core sequencing pulses
//   core_key, core_in     : operands held stable for the core
//   core_out, core_done   : core result and its strobe
//   err                   : sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module aes_stream_adapter
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [AES_BYTE_W-1:0]  s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [AES_BYTE_W-1:0]  m_data,
  output logic                   m_last,
  output logic                   core_clr,
  output logic                   core_start,
  output logic [AES_BLOCK_W-1:0] core_key,
  output logic [AES_BLOCK_W-1:0] core_in,
  input  logic [AES_BLOCK_W-1:0] core_out,
  input  logic                   core_done,
  output logic                   err
);

  localparam logic [CW-1:0] WD_LAST    = CW'(TIMEOUT - 1);
  localparam logic [4:0]    FRAME_LAST = 5'(AES_FRAME_BYTES - 1);

  aes_state_e             state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [CW-1:0]          wd_q, wd_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d;
  logic [AES_BLOCK_W-1:0] in_q, in_d;
  logic                   err_q, err_d;
  logic                   clr_q, clr_d;
  logic                   start_q, start_d;
  logic                   s_beat;
  logic                   load_res;
  logic                   drain_done;

  assign s_ready    = (state_q == COLLECT);
  assign m_valid    = (state_q == DRAIN);
  assign s_beat     = s_valid & s_ready;
  assign core_clr   = clr_q;
  assign core_start = start_q;
  assign core_key   = key_q;
  assign core_in    = in_q;
  assign err        = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    key_d    = key_q;
    in_d     = in_q;
    err_d    = err_q;
    clr_d    = 1'b0;
    start_d  = 1'b0;
    load_res = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (s_beat) begin
          cnt_d = cnt_q + 5'd1;
          // count[4] splits the frame: low half is key, high half plaintext
          if (!cnt_q[4]) key_d = {key_q[AES_BLOCK_W-AES_BYTE_W-1:0], s_data};
          else           in_d  = {in_q[AES_BLOCK_W-AES_BYTE_W-1:0], s_data};
          if (cnt_q == FRAME_LAST) begin
            cnt_d   = 5'd0;
            state_d = CLEAR;
            // registered pulse lands in the CLEAR cycle itself
            clr_d   = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = START;
        start_d = 1'b1;
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done takes priority over a timeout in the same cycle
        if (core_done) begin
          load_res = 1'b1;
          state_d  = DRAIN;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = COLLECT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_done) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= 5'd0;
      wd_q    <= '0;
      key_q   <= '0;
      in_q    <= '0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      key_q   <= key_d;
      in_q    <= in_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      start_q <= start_d;
    end
  end

  aes_out_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_res),
    .data_i     (core_out),
    .valid_i    (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_last_o   (m_last),
    .last_beat_o(drain_done)
  );

endmodule

// File: tb/tb_aes_stream_adapter.sv
module tb_aes_stream_adapter;
  import aes_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int CW      = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready;
  logic [7:0]   s_data;
  logic         m_valid, m_ready, m_last;
  logic [7:0]   m_data;
  logic         core_clr, core_start, core_done, err;
  logic [127:0] core_key, core_in, core_out;

  aes_stream_adapter #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_clr(core_clr), .core_start(core_start),
    .core_key(core_key), .core_in(core_in),
    .core_out(core_out), .core_done(core_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // main-process controls for the core model and the sink
  int lat       = 40;
  bit hang      = 1'b0;
  int spur_cnt  = 0;
  int rdy_mode  = 0;

  // core model state
  int core_seen = 0;
  bit pend      = 1'b0;
  int due       = 0;
  int done_q[$];

  // sink state
  logic [8:0] byte_q[$];
  int mv_q[$];
  int stall_n   = 0;
  int stall_bad = 0;

  // clr/start monitor
  int clr_n = 0, clr_cyc = 0, start_n = 0, start_cyc = 0;
  logic [127:0] clr_key, clr_in;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stand-in for the AES core: known FIPS pairs map to their ciphertext,
  // anything else to a fixed keyed scramble.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY_A && p == FIPS_PT_A) return FIPS_CT_A;
    if (k == FIPS_KEY_B && p == FIPS_PT_B) return FIPS_CT_B;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0f0f_c3c3_9696_1234_5678_9abc_def0;
  endfunction

  // core model
  initial begin
    core_done = 1'b0;
    core_out  = '0;
    forever begin
      tick();
      core_done = 1'b0;
      core_out  = {$urandom, $urandom, $urandom, $urandom};
      if (rst) pend = 1'b0;
      else begin
        if (spur_cnt != core_seen) begin
          core_seen = spur_cnt;
          core_done = 1'b1;
          core_out  = '1;
        end
        if (pend && cyc == due) begin
          core_done = 1'b1;
          core_out  = core_fn(core_key, core_in);
          done_q.push_back(cyc);
          pend = 1'b0;
        end
        if (core_start && !hang) begin
          pend = 1'b1;
          due  = cyc + lat;
        end
      end
    end
  end

  // sink
  initial begin
    int bidx = 0, stall_left = 0;
    bit stall_done = 1'b0, pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = '0;
    m_ready = 1'b0;
    forever begin
      tick();
      if (rst) begin
        bidx = 0; pv = 1'b0; stall_left = 0; stall_done = 1'b0; m_ready = 1'b0;
      end else begin
        if (pv && !pr) begin
          stall_n++;
          if (m_data !== pd || m_last !== pl) stall_bad++;
        end
        if (m_valid && !pv) mv_q.push_back(cyc);
        case (rdy_mode)
          0: m_ready = 1'b1;
          1: m_ready = 1'($urandom_range(0, 1));
          default: begin
            if (bidx == 5 && !stall_done) begin
              stall_left = 3;
              stall_done = 1'b1;
            end
            if (stall_left > 0) begin
              m_ready = 1'b0;
              stall_left--;
            end else m_ready = 1'b1;
          end
        endcase
        if (m_valid && m_ready) begin
          byte_q.push_back({m_last, m_data});
          if (bidx == 15) begin
            bidx = 0;
            stall_done = 1'b0;
          end else bidx++;
        end
        pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      end
    end
  end

  // clr/start monitor
  initial begin
    forever begin
      tick();
      if (core_clr) begin
        clr_n++;
        clr_cyc = cyc;
        clr_key = core_key;
        clr_in  = core_in;
      end
      if (core_start) begin
        start_n++;
        start_cyc = cyc;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "global timeout");
  end

  task automatic send(input logic [127:0] key, input logic [127:0] pt, input int nbytes,
                      input bit gaps, input int spur_at, output int t);
    logic [255:0] fr;
    int guard;
    fr = {key, pt};
    t  = 0;
    for (int i = 0; i < nbytes; i++) begin
      if (i == spur_at) spur_cnt++;
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          s_valid = 1'b0;
          tick();
        end
      end
      s_valid = 1'b1;
      s_data  = fr[255-8*i -: 8];
      guard   = 0;
      while (!s_ready && guard < 300) begin
        tick();
        guard++;
      end
      if (guard >= 300) begin
        check_val("s_ready_wait", 0, 1);
        $fatal(1, "s_ready never rose");
      end
      t = cyc;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input string nm, input logic [127:0] key, input logic [127:0] pt,
                           input bit gaps, input int spur_at);
    int t, c0, s0, b0, guard;
    logic [127:0] exp;
    logic [8:0] e;
    c0  = clr_n;
    s0  = start_n;
    b0  = byte_q.size();
    exp = core_fn(key, pt);
    send(key, pt, 32, gaps, spur_at, t);
    tick();
    tick();
    check_val({nm, "_clr_n"},     clr_n, c0 + 1);
    check_val({nm, "_clr_cyc"},   clr_cyc, t + 1);
    check_val({nm, "_start_n"},   start_n, s0 + 1);
    check_val({nm, "_start_cyc"}, start_cyc, t + 2);
    check_val({nm, "_key"},       clr_key, key);
    check_val({nm, "_pt"},        clr_in, pt);
    guard = 0;
    while (byte_q.size() < b0 + 16 && guard < 600) begin
      tick();
      guard++;
    end
    check_val({nm, "_nbytes"}, byte_q.size(), b0 + 16);
    for (int k = 0; k < 16; k++) begin
      if (b0 + k < byte_q.size()) begin
        e = byte_q[b0+k];
        check_val({nm, "_byte"}, e[7:0], exp[127-8*k -: 8]);
        check_val({nm, "_last"}, e[8], (k == 15));
      end
    end
    if (mv_q.size() > 0 && done_q.size() > 0)
      check_val({nm, "_done_to_valid"}, mv_q[mv_q.size()-1], done_q[done_q.size()-1] + 1);
    else
      check_val({nm, "_done_seen"}, 0, 1);
    tick();
    tick();
    check_val({nm, "_sready_after"}, s_ready, 1);
    check_val({nm, "_mvalid_after"}, m_valid, 0);
  endtask

  task automatic check_reset_vals(input string nm);
    check_val({nm, "_s_ready"},    s_ready, 1);
    check_val({nm, "_m_valid"},    m_valid, 0);
    check_val({nm, "_m_last"},     m_last, 0);
    check_val({nm, "_m_data"},     m_data, 0);
    check_val({nm, "_core_clr"},   core_clr, 0);
    check_val({nm, "_core_start"}, core_start, 0);
    check_val({nm, "_core_key"},   core_key, 0);
    check_val({nm, "_core_in"},    core_in, 0);
    check_val({nm, "_err"},        err, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int t, s0, mv0, b0, guard, errc;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    tick();
    tick();
    check_reset_vals("por");
    rst = 1'b0;
    tick();

    // FIPS C.1, sink always ready
    lat = 40; rdy_mode = 0;
    run_frame("fips_a", FIPS_KEY_A, FIPS_PT_A, 1'b0, -1);
    check_val("fips_a_err", err, 0);

    // FIPS B, random input gaps, 3-cycle stall mid-drain
    rdy_mode = 2; lat = 17;
    run_frame("fips_b", FIPS_KEY_B, FIPS_PT_B, 1'b1, -1);
    check_val("stall_cycles", stall_n, 3);
    check_val("stall_hold", stall_bad, 0);

    // spurious done while collecting must be ignored
    rdy_mode = 0; lat = 25;
    mv0 = mv_q.size();
    run_frame("spur", FIPS_KEY_A, FIPS_PT_A, 1'b0, 10);
    check_val("spur_one_burst", mv_q.size(), mv0 + 1);

    // randomized frames
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(1, 50);
      run_frame("rand", rnd128(), rnd128(), 1'b1, -1);
    end

    // done arriving on the very cycle the watchdog expires
    lat = TIMEOUT;
    run_frame("edge_done", rnd128(), rnd128(), 1'b0, -1);
    check_val("edge_done_err", err, 0);

    // core never completes
    hang = 1'b1; rdy_mode = 0;
    s0 = start_n; mv0 = mv_q.size(); b0 = byte_q.size();
    send(rnd128(), rnd128(), 32, 1'b0, -1, t);
    tick();
    tick();
    check_val("to_start_seen", start_n, s0 + 1);
    guard = 0;
    while (!err && guard < 300) begin
      tick();
      guard++;
    end
    errc = cyc;
    check_val("to_err", err, 1);
    check_val("to_err_cyc", errc, start_cyc + 1 + TIMEOUT);
    check_val("to_sready", s_ready, 1);
    repeat (5) tick();
    check_val("to_no_mvalid", mv_q.size(), mv0);
    check_val("to_no_bytes", byte_q.size(), b0);
    hang = 1'b0; lat = 33;
    run_frame("after_to", rnd128(), rnd128(), 1'b0, -1);
    check_val("err_sticky", err, 1);

    // reset mid-frame, then a fresh frame
    send(rnd128(), rnd128(), 20, 1'b0, -1, t);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    tick();
    rst = 1'b0;
    tick();
    lat = 40;
    run_frame("post_rst", FIPS_KEY_B, FIPS_PT_B, 1'b1, -1);
    check_val("post_rst_err", err, 0);
    check_val("stall_hold_end", stall_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
